// File: rtl/icache_pkg.sv
// icache_pkg: shared types and geometry helpers for the instruction cache.
// No ports; default LINES/WPL, state enum, decoded-address struct.
package icache_pkg;

  localparam int LINES_DEF = 64;
  localparam int WPL_DEF   = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Fields are full width so the struct fits any geometry;
  // users slice the low IW/OW/TAG_W bits.
  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] word;
  } addr_t;

  function automatic int iw_of(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int ow_of(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int tag_w_of(input int lines, input int wpl);
    return 32 - $clog2(lines) - $clog2(wpl) - 2;
  endfunction

  function automatic addr_t decode(input logic [31:0] pa,
                                   input int iw, input int ow);
    addr_t a;
    a.word  = (pa >> 2) & ((32'd1 << ow) - 32'd1);
    a.index = (pa >> (ow + 2)) & ((32'd1 << iw) - 32'd1);
    a.tag   = pa >> (iw + ow + 2);
    return a;
  endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// icache_fetch_if: fetch-side and memory-refill signals of the icache.
// slave = cache view; master = fetch stage + memory view.
interface icache_fetch_if;
  logic        FETCH_REQ;
  logic [31:0] FETCH_PA;
  logic        FETCH_EXC;
  logic        INVALIDATE;
  logic [31:0] INST;
  logic        INST_VALID;
  logic        STALL;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_VALID;
  logic [31:0] MEM_RDATA;

  modport slave (
    input  FETCH_REQ, FETCH_PA, FETCH_EXC, INVALIDATE,
    input  MEM_VALID, MEM_RDATA,
    output INST, INST_VALID, STALL, MEM_REQ, MEM_ADDR
  );

  modport master (
    output FETCH_REQ, FETCH_PA, FETCH_EXC, INVALIDATE,
    output MEM_VALID, MEM_RDATA,
    input  INST, INST_VALID, STALL, MEM_REQ, MEM_ADDR
  );
endinterface

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays, comb read, clocked writes.
// Ports: i_clk/i_rst, read idx/word -> valid/tag/data, word write,
// tag+valid write (at i_wr_idx), flash-clear of all valid bits.
module icache_line_store #(
  parameter int LINES = 64,
  parameter int WPL   = 4,
  parameter int IW    = 6,
  parameter int OW    = 2,
  parameter int TAG_W = 22
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IW-1:0]    i_rd_idx,
  input  logic [OW-1:0]    i_rd_word,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic [OW-1:0]    i_wr_word,
  input  logic [31:0]      i_wr_data,
  input  logic             i_tag_we,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_tag_valid,
  input  logic             i_clr
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES*WPL];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[{i_rd_idx, i_rd_word}];

  always_ff @(posedge i_clk) begin
    if (i_wr_en)
      r_data[{i_wr_idx, i_wr_word}] <= i_wr_data;
    if (i_tag_we)
      r_tag[i_wr_idx] <= i_tag;
  end

  // Line write after flash-clear so a cleared line can still be
  // written (with valid=0 when an invalidate is pending).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      if (i_clr)
        r_valid <= '0;
      if (i_tag_we)
        r_valid[i_wr_idx] <= i_tag_valid;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only icache after the MMU.
// Ports: CLK, RESET (async, high), bus (icache_fetch_if.slave),
// HIT_CNT/MISS_CNT (live only with ICACHE_STATS_EN, else 0).
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WPL   = WPL_DEF
) (
  input  logic           CLK,
  input  logic           RESET,
  icache_fetch_if.slave  bus,
  output logic [31:0]    HIT_CNT,
  output logic [31:0]    MISS_CNT
);

  localparam int IW    = iw_of(LINES);
  localparam int OW    = ow_of(WPL);
  localparam int TAG_W = tag_w_of(LINES, WPL);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_REFILL = REFILL;

  logic [0:0]       r_state;
  logic [TAG_W-1:0] r_tag;
  logic [IW-1:0]    r_idx;
  logic [OW-1:0]    r_cnt;
  logic             r_pend;

  addr_t            w_pa;
  logic [TAG_W-1:0] w_tag;
  logic [IW-1:0]    w_idx;
  logic [OW-1:0]    w_word;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_data;
  logic             w_idle;
  logic             w_look;
  logic             w_hit;
  logic             w_miss;
  logic             w_ack;
  logic             w_last;
  logic             w_inv_any;
  logic             w_clr;
  logic             w_unused;

  assign w_pa   = decode(bus.FETCH_PA, IW, OW);
  assign w_tag  = w_pa.tag[TAG_W-1:0];
  assign w_idx  = w_pa.index[IW-1:0];
  assign w_word = w_pa.word[OW-1:0];

  assign w_unused = ^{1'b0, w_pa.tag[31:TAG_W],
                      w_pa.index[31:IW], w_pa.word[31:OW]};

  assign w_idle = (r_state == ST_IDLE);
  assign w_look = w_idle & bus.FETCH_REQ & ~bus.FETCH_EXC;
  assign w_hit  = w_look & w_rd_valid & (w_rd_tag == w_tag);
  assign w_miss = w_look & ~w_hit;
  assign w_ack  = ~w_idle & bus.MEM_VALID;
  assign w_last = w_ack & (r_cnt == OW'(WPL - 1));

  // An invalidate landing on the last beat counts as pending.
  assign w_inv_any = r_pend | bus.INVALIDATE;
  assign w_clr     = (w_idle & bus.INVALIDATE)
                   | (w_last & w_inv_any);

  assign bus.INST       = w_hit ? w_rd_data : 32'd0;
  assign bus.INST_VALID = w_hit;
  assign bus.STALL      = ~w_idle | w_miss;
  assign bus.MEM_REQ    = ~w_idle;
  assign bus.MEM_ADDR   = {r_tag, r_idx, r_cnt, 2'b00};

  icache_line_store #(
    .LINES (LINES),
    .WPL   (WPL),
    .IW    (IW),
    .OW    (OW),
    .TAG_W (TAG_W)
  ) u_store (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_rd_idx    (w_idx),
    .i_rd_word   (w_word),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_ack),
    .i_wr_idx    (r_idx),
    .i_wr_word   (r_cnt),
    .i_wr_data   (bus.MEM_RDATA),
    .i_tag_we    (w_last),
    .i_tag       (r_tag),
    .i_tag_valid (~w_inv_any),
    .i_clr       (w_clr)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_tag   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_state <= ST_REFILL;
            r_tag   <= w_tag;
            r_idx   <= w_idx;
            r_cnt   <= '0;
          end
        end
        ST_REFILL: begin
          if (bus.INVALIDATE)
            r_pend <= 1'b1;
          if (w_ack)
            r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_pend  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign HIT_CNT  = r_hit_cnt;
  assign MISS_CNT = r_miss_cnt;
`else
  assign HIT_CNT  = 32'd0;
  assign MISS_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: directed table + random test of icache_fetch.
// Reference model tracks which line base address each index holds.
module tb_icache_fetch;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] HIT_CNT;
  logic [31:0] MISS_CNT;

  icache_fetch_if bus();

  icache_fetch dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus      (bus),
    .HIT_CNT  (HIT_CNT),
    .MISS_CNT (MISS_CNT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  bit          mv [64];
  logic [31:0] mb [64];
  int          m_hits;
  int          m_miss;

  typedef struct {
    logic [31:0] pa;
    bit          req;
    bit          exc;
    int          reps;
    bit          vld;
    bit          stl;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic quiet;
    bus.FETCH_REQ  = 1'b0;
    bus.FETCH_EXC  = 1'b0;
    bus.INVALIDATE = 1'b0;
    bus.MEM_VALID  = 1'b0;
    bus.FETCH_PA   = 32'd0;
    bus.MEM_RDATA  = 32'd0;
  endtask

  task automatic do_reset;
    quiet();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic apply(input string nm, input logic [31:0] pa,
                       input bit req, input bit exc, input bit inv,
                       input bit e_vld, input bit e_stl,
                       input logic [31:0] e_inst);
    @(negedge CLK);
    bus.FETCH_PA   = pa;
    bus.FETCH_REQ  = req;
    bus.FETCH_EXC  = exc;
    bus.INVALIDATE = inv;
    bus.MEM_VALID  = 1'b0;
    bus.MEM_RDATA  = $urandom;
    #1;
    chk({nm, " inst_valid"}, 32'(bus.INST_VALID), 32'(e_vld));
    chk({nm, " stall"}, 32'(bus.STALL), 32'(e_stl));
    chk({nm, " mem_req"}, 32'(bus.MEM_REQ), 32'd0);
    if (e_vld || exc)
      chk({nm, " inst"}, bus.INST, e_inst);
  endtask

  // One beat per word, in order; directed mode waits one cycle per beat.
  task automatic refill(input string nm, input logic [31:0] lb,
                        input bit rnd, input int inv_word,
                        output bit inv_seen);
    int gap;
    inv_seen = 1'b0;
    for (int w = 0; w < 4; w++) begin
      gap = rnd ? int'($urandom_range(0, 2)) : 1;
      for (int g = 0; g <= gap; g++) begin
        @(negedge CLK);
        bus.MEM_VALID = (g == gap);
        bus.MEM_RDATA = (g == gap) ? mem(lb + 32'(w * 4)) : $urandom;
        if (rnd) begin
          bus.FETCH_REQ  = 1'($urandom_range(0, 1));
          bus.FETCH_PA   = $urandom;
          bus.FETCH_EXC  = ($urandom_range(0, 3) == 0);
          bus.INVALIDATE = ($urandom_range(0, 7) == 0);
        end else begin
          bus.INVALIDATE = (w == inv_word) && (g == 0);
        end
        inv_seen = inv_seen | bus.INVALIDATE;
        #1;
        chk($sformatf("%s mem_req w%0d", nm, w),
            32'(bus.MEM_REQ), 32'd1);
        chk($sformatf("%s mem_addr w%0d", nm, w),
            bus.MEM_ADDR, lb + 32'(w * 4));
        chk($sformatf("%s stall w%0d", nm, w),
            32'(bus.STALL), 32'd1);
        chk($sformatf("%s inst_valid w%0d", nm, w),
            32'(bus.INST_VALID), 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          dmy;
    logic [31:0] pa;
    logic [31:0] lb;
    int          li;
    bit          req;
    bit          exc;
    bit          inv;
    bit          look;
    bit          hit;

    tbl[0]  = '{32'h0000_0100, 1, 0, 1, 0, 1, 32'd0};
    tbl[1]  = '{32'h0000_0100, 1, 0, 1, 1, 0, mem(32'h100)};
    tbl[2]  = '{32'h0000_0108, 1, 0, 1, 1, 0, mem(32'h108)};
    tbl[3]  = '{32'h0000_010F, 1, 0, 1, 1, 0, mem(32'h10C)};
    tbl[4]  = '{32'h0000_0500, 1, 0, 1, 0, 1, 32'd0};
    tbl[5]  = '{32'h0000_0504, 1, 0, 1, 1, 0, mem(32'h504)};
    tbl[6]  = '{32'h0000_0100, 1, 0, 1, 0, 1, 32'd0};
    tbl[7]  = '{32'h8000_0000, 1, 1, 5, 0, 0, 32'd0};
    tbl[8]  = '{32'h0000_0100, 0, 0, 1, 0, 0, 32'd0};
    tbl[9]  = '{32'h0000_0100, 1, 0, 1, 1, 0, mem(32'h100)};
    tbl[10] = '{32'h8000_0000, 1, 0, 1, 0, 1, 32'd0};
    tbl[11] = '{32'h8000_000C, 1, 0, 1, 1, 0, mem(32'h8000_000C)};

    // Reset state
    quiet();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst mem_req", 32'(bus.MEM_REQ), 32'd0);
    chk("rst mem_addr", bus.MEM_ADDR, 32'd0);
    chk("rst stall", 32'(bus.STALL), 32'd0);
    chk("rst inst_valid", 32'(bus.INST_VALID), 32'd0);
    chk("rst hit_cnt", HIT_CNT, 32'd0);
    chk("rst miss_cnt", MISS_CNT, 32'd0);
    RESET = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        apply($sformatf("tbl%0d", i), tbl[i].pa, tbl[i].req,
              tbl[i].exc, 1'b0, tbl[i].vld, tbl[i].stl, tbl[i].inst);
        if (tbl[i].stl)
          refill($sformatf("tbl%0d", i), tbl[i].pa & ~32'hF,
                 1'b0, -1, dmy);
      end
    end

    // Invalidate on the 2nd beat of a refill of 0x200
    apply("inv miss200", 32'h200, 1, 0, 0, 0, 1, 32'd0);
    refill("inv fill200", 32'h200, 1'b0, 1, dmy);
    apply("inv re200", 32'h200, 1, 0, 0, 0, 1, 32'd0);
    refill("inv refill200", 32'h200, 1'b0, -1, dmy);
    apply("inv re100", 32'h100, 1, 0, 0, 0, 1, 32'd0);
    refill("inv refill100", 32'h100, 1'b0, -1, dmy);
    apply("inv hit200", 32'h204, 1, 0, 0, 1, 0, mem(32'h204));

    // Idle invalidate: same-cycle lookup sees the old state
    apply("idle inv", 32'h104, 1, 0, 1, 1, 0, mem(32'h104));
    apply("after inv", 32'h100, 1, 0, 0, 0, 1, 32'd0);

    // Reset during beat 2 of that refill
    for (int w = 0; w < 2; w++) begin
      @(negedge CLK);
      bus.INVALIDATE = 1'b0;
      bus.MEM_VALID  = 1'b1;
      bus.MEM_RDATA  = mem(32'h100 + 32'(w * 4));
    end
    @(negedge CLK);
    bus.MEM_VALID = 1'b0;
    #1;
    chk("rstmid addr w2", bus.MEM_ADDR, 32'h108);
    chk("rstmid req w2", 32'(bus.MEM_REQ), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rstmid req drop", 32'(bus.MEM_REQ), 32'd0);
    chk("rstmid addr", bus.MEM_ADDR, 32'd0);
    bus.FETCH_REQ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    apply("rstmid miss", 32'h100, 1, 0, 0, 0, 1, 32'd0);
    refill("rstmid fill", 32'h100, 1'b0, -1, dmy);
    apply("stats hit0", 32'h100, 1, 0, 0, 1, 0, mem(32'h100));
    apply("stats hit1", 32'h104, 1, 0, 0, 1, 0, mem(32'h104));
    apply("stats hit2", 32'h108, 1, 0, 0, 1, 0, mem(32'h108));
    #1;
`ifdef ICACHE_STATS_EN
    chk("stats hit_cnt", HIT_CNT, 32'd3);
    chk("stats miss_cnt", MISS_CNT, 32'd1);
`else
    chk("stats hit_cnt", HIT_CNT, 32'd0);
    chk("stats miss_cnt", MISS_CNT, 32'd0);
`endif

    // Random traffic against the line-address model
    do_reset();
    foreach (mv[k]) mv[k] = 1'b0;
    m_hits = 0;
    m_miss = 0;
    for (int n = 0; n < 300; n++) begin
      pa = (32'($urandom_range(0, 3)) << 10)
         | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2)
         | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        pa = pa | 32'h8000_0000;
      req  = ($urandom_range(0, 7) != 0);
      exc  = ($urandom_range(0, 7) == 0);
      inv  = ($urandom_range(0, 15) == 0);
      li   = int'((pa >> 4) % 64);
      lb   = pa & ~32'hF;
      look = req && !exc;
      hit  = look && mv[li] && (mb[li] == lb);
      apply($sformatf("rnd%0d", n), pa, req, exc, inv, hit,
            look && !hit, hit ? mem(pa & ~32'h3) : 32'd0);
      if (hit) m_hits++;
      if (inv) foreach (mv[k]) mv[k] = 1'b0;
      if (look && !hit) begin
        m_miss++;
        refill($sformatf("rnd%0d", n), lb, 1'b1, -1, dmy);
        if (dmy) begin
          foreach (mv[k]) mv[k] = 1'b0;
        end else begin
          mv[li] = 1'b1;
          mb[li] = lb;
        end
      end
    end
    @(negedge CLK);
    quiet();
    #1;
`ifdef ICACHE_STATS_EN
    chk("rnd hit_cnt", HIT_CNT, 32'(m_hits));
    chk("rnd miss_cnt", MISS_CNT, 32'(m_miss));
`else
    chk("rnd hit_cnt", HIT_CNT, 32'd0);
    chk("rnd miss_cnt", MISS_CNT, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache directly downstream of the MMU.
- Consumes the translated instruction physical address and the ifetch exception flags (iTLBL | iADEL).
- Returns the instruction word on a hit. On a miss it stalls the fetch stage and refills one line from the memory bus, one word per handshake.

Parameters:
- LINES, 64, number of cache lines (power of two; index width IW = log2(LINES)).
- WPL, 4, 32-bit words per line (power of two; offset width OW = log2(WPL)).
- TAG_W, 32-IW-OW-2, tag width (derived localparam, not overridable).

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- FETCH_REQ  in  1  fetch stage wants an instruction this cycle
- FETCH_PA  in  32  physical address from MMU INST_PA (word aligned; bits [1:0] ignored)
- FETCH_EXC  in  1  iTLBL | iADEL; suppresses lookup and refill
- INVALIDATE  in  1  one-cycle pulse; clear all valid bits
- INST  out  32  instruction word
- INST_VALID  out  1  INST valid this cycle (hit)
- STALL  out  1  fetch must hold FETCH_PA and retry
- MEM_REQ  out  1  refill word request
- MEM_ADDR  out  32  refill word address
- MEM_VALID  in  1  memory returns MEM_RDATA for current MEM_ADDR
- MEM_RDATA  in  32  refill data
- HIT_CNT  out  32  hit counter (see Optional Feature)
- MISS_CNT  out  32  miss counter (see Optional Feature)

Behaviour:
- Address split: tag = PA[31:IW+OW+2], index = PA[IW+OW+1:OW+2], word = PA[OW+1:2].
- Arrays: valid[LINES], tag[LINES], data[LINES][WPL]. All reads are combinational; writes are clocked.
- Reset (async): FSM to IDLE, all valid bits 0, MEM_REQ=0, MEM_ADDR=0, refill counter 0, pending-invalidate 0, counters 0. Data and tag arrays are not reset.
- States: IDLE, REFILL.
- IDLE, FETCH_REQ & ~FETCH_EXC:
  - hit = valid[index] & tag match.
  - Hit: INST = data[index][word], INST_VALID=1, STALL=0, same cycle (zero latency).
  - Miss: INST_VALID=0, STALL=1 same cycle. Latch line base {tag,index}. Counter = 0. Go to REFILL.
- IDLE, FETCH_EXC=1: INST=0, INST_VALID=0, STALL=0; no state change. The exception has priority over REQ.
- IDLE, FETCH_REQ=0: INST_VALID=0, STALL=0.
- REFILL:
  - Outputs: MEM_REQ=1, MEM_ADDR = {latched tag, latched index, counter, 2'b00}, STALL=1, INST_VALID=0.
  - Fill order is word 0 to WPL-1 (no critical-word-first).
  - On each MEM_VALID: write MEM_RDATA to data[index][counter], then counter+1. MEM_ADDR updates next cycle.
  - MEM_VALID may arrive any cycle, including the first REFILL cycle.
  - On MEM_VALID with counter == WPL-1: write the tag, set valid, go to IDLE next cycle. The retried fetch hits there.
  - Miss penalty: WPL handshakes + 1 cycle.
- FETCH_REQ dropping or FETCH_PA changing during REFILL: the refill still completes with the latched line; inputs are ignored until IDLE.
- FETCH_EXC rising during REFILL: ignored; the refill completes.
- INVALIDATE in IDLE: all valid bits cleared at the next edge. A same-cycle lookup uses the pre-clear state.
- INVALIDATE during REFILL: pending flag set. When the last word lands, the line is written with valid=0 and every other valid bit is cleared; the flag is then cleared.
- Async RESET mid-REFILL: MEM_REQ drops immediately and the partial line is discarded (valid stays 0). Memory must tolerate an abandoned request.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - HIT_CNT increments on each IDLE lookup hit.
  - MISS_CNT increments on each IDLE→REFILL transition.
  - Both wrap at 2^32 and reset to 0.
- Undefined: HIT_CNT and MISS_CNT are tied to 0 and no counter flops exist.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, REFILL);
  - default LINES/WPL;
  - a function computing IW, OW and TAG_W;
  - a typedef for the decoded address struct {tag, index, word}.
- Sub-module icache_line_store: valid/tag/data arrays with combinational read port, single word-write port, tag+valid write, and flash-clear. The top level holds the FSM, refill counter and counters.

Test Plan:
- After reset: fetch PA 0x0000_0100 → STALL=1, MEM_ADDR 0x100, 0x104, 0x108, 0x10C with MEM_VALID one cycle later each → next cycle INST_VALID=1, INST = word written for 0x100. A fetch of 0x108 hits with zero latency.
- Conflict miss: fill 0x100, then fetch 0x0000_0500 (same index, different tag) → refill from 0x500. A fetch of 0x100 then misses again.
- FETCH_EXC=1 with FETCH_PA 0x8000_0000 → INST_VALID=0, STALL=0, MEM_REQ stays 0 for 5 cycles.
- INVALIDATE pulse during the 2nd word of a refill of 0x200 → refill completes (4 words). Refetch of 0x200 misses and an earlier-filled 0x100 also misses.
- Assert RESET while MEM_REQ=1 at word 2 → MEM_REQ=0 in the same cycle. After release, fetch 0x100 misses and refills from word 0.
- With ICACHE_STATS_EN: 1 miss + 3 hits → MISS_CNT=1, HIT_CNT=3. Without the macro both read 0.
